// File: rtl/swu_ram_reader.sv
// Read-side controller for the sliding-window line buffer: issues narrow-port reads in
// circular order and streams the registered RAM data out through a 2-entry skid buffer.
module swu_ram_reader #(
    parameter int WIDTHB     = 4,
    parameter int SIZEB      = 1024,
    parameter int ADDRWIDTHB = 10,
    parameter int RATIO      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(RATIO+1)-1:0]     fill_inc,
    output logic                           ram_enaB,
    output logic [ADDRWIDTHB-1:0]          ram_addrB,
    input  logic [WIDTHB-1:0]              ram_doB,
    output logic [WIDTHB-1:0]              m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           rd_free,
    output logic [ADDRWIDTHB:0]            avail,
    output logic                           ovf_err
);

    localparam int                    SUMW     = ADDRWIDTHB + 2;
    localparam logic [SUMW-1:0]       SIZE_S   = SUMW'(SIZEB);
    localparam logic [ADDRWIDTHB-1:0] LAST_PTR = ADDRWIDTHB'(SIZEB - 1);

    logic [ADDRWIDTHB-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTHB:0]   avail_q, avail_d;
    logic                  ovf_q, ovf_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            count_q, count_d;
    logic [WIDTHB-1:0]     head_q, head_d;
    logic [WIDTHB-1:0]     tail_q, tail_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [1:0]            occ;
    logic [1:0]            level;
    logic [SUMW-1:0]       fill_sum;
    logic [SUMW-1:0]       net_sum;

    // NOTE: every signal assigned in this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        head_d     = head_q;
        tail_d     = tail_q;

        pop  = (count_q != 2'd0) && m_tready;
        push = inflight_q;
        occ  = count_q + {1'b0, inflight_q};

        // A read may be issued into the slot that a same-cycle pop frees up.
        issue = (avail_q != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
        inflight_d = issue;

        if (issue) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDRWIDTHB'(1);
        end

        fill_sum = SUMW'(avail_q) + SUMW'(fill_inc);
        net_sum  = fill_sum - SUMW'(issue);
        ovf_d    = ovf_q | (fill_sum > SIZE_S);
        avail_d  = (net_sum > SIZE_S) ? SIZE_S[ADDRWIDTHB:0] : net_sum[ADDRWIDTHB:0];

        // Skid buffer: head is the registered output beat, tail holds the second entry.
        level   = count_q - {1'b0, pop};
        count_d = level + {1'b0, push};
        if (pop) begin
            head_d = tail_q;
        end
        if (push) begin
            if (level == 2'd0) begin
                head_d = ram_doB;
            end else begin
                tail_d = ram_doB;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            avail_q    <= '0;
            ovf_q      <= 1'b0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            avail_q    <= avail_d;
            ovf_q      <= ovf_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: the second skid entry is pure data qualified by count_q, so it carries no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

    assign ram_enaB  = issue;
    assign ram_addrB = rd_ptr_q;
    assign m_tdata   = head_q;
    assign m_tvalid  = (count_q != 2'd0);
    assign rd_free   = inflight_q;
    assign avail     = avail_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_swu_ram_reader.sv
// Directed bench for swu_ram_reader: a default-sized instance and a SIZEB=6 instance,
// each fed by a 1-cycle registered RAM model.
module tb_swu_ram_reader;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default parameters
    logic [2:0]  fill_a;
    logic        ena_a;
    logic [9:0]  addr_a;
    logic [3:0]  do_a;
    logic [3:0]  tdata_a;
    logic        tvalid_a;
    logic        tready_a;
    logic        free_a;
    logic [10:0] avail_a;
    logic        ovf_a;
    logic [3:0]  mem_a [1024];

    // Instance B: SIZEB=6
    logic [2:0]  fill_b;
    logic        ena_b;
    logic [2:0]  addr_b;
    logic [3:0]  do_b;
    logic [3:0]  tdata_b;
    logic        tvalid_b;
    logic        tready_b;
    logic        free_b;
    logic [3:0]  avail_b;
    logic        ovf_b;
    logic [3:0]  mem_b [6];

    swu_ram_reader u_dut_a (
        .clk(clk), .rst(rst), .fill_inc(fill_a),
        .ram_enaB(ena_a), .ram_addrB(addr_a), .ram_doB(do_a),
        .m_tdata(tdata_a), .m_tvalid(tvalid_a), .m_tready(tready_a),
        .rd_free(free_a), .avail(avail_a), .ovf_err(ovf_a)
    );

    swu_ram_reader #(.WIDTHB(4), .SIZEB(6), .ADDRWIDTHB(3), .RATIO(4)) u_dut_b (
        .clk(clk), .rst(rst), .fill_inc(fill_b),
        .ram_enaB(ena_b), .ram_addrB(addr_b), .ram_doB(do_b),
        .m_tdata(tdata_b), .m_tvalid(tvalid_b), .m_tready(tready_b),
        .rd_free(free_b), .avail(avail_b), .ovf_err(ovf_b)
    );

    always @(posedge clk) begin
        if (ena_a) do_a <= mem_a[addr_a];
        if (ena_b) do_b <= mem_b[addr_b];
    end

    // Monitors only append; each test compares from a snapshot of the queue sizes.
    int iss_addr_a[$], iss_cyc_a[$], beat_a[$], beat_cyc_a[$];
    int iss_addr_b[$], beat_b[$];
    int nfree_a = 0;
    int nfree_b = 0;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (ena_a) begin
                iss_addr_a.push_back(int'(addr_a));
                iss_cyc_a.push_back(cyc);
            end
            if (free_a) nfree_a++;
            if (tvalid_a && tready_a) begin
                beat_a.push_back(int'(tdata_a));
                beat_cyc_a.push_back(cyc);
            end
            if (ena_b) iss_addr_b.push_back(int'(addr_b));
            if (free_b) nfree_b++;
            if (tvalid_b && tready_b) beat_b.push_back(int'(tdata_b));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    logic [3:0] pat_a2 [8] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h5};
    logic [3:0] pat_b  [6] = '{4'h3, 4'h9, 4'h5, 4'hC, 4'h1, 4'h7};
    int         fill_tab [10] = '{2, 1, 0, 3, 1, 2, 1, 0, 2, 2};

    int ia, ic, ba, bc, fa, ib, bb, fb;

    initial begin
        rst = 1'b1; fill_a = '0; fill_b = '0; tready_a = 1'b1; tready_b = 1'b1;
        for (int i = 0; i < 1024; i++) mem_a[i] = '0;
        for (int i = 0; i < 4; i++) mem_a[i] = 4'(i + 1);
        for (int i = 0; i < 8; i++) mem_a[4 + i] = pat_a2[i];
        for (int i = 0; i < 6; i++) mem_b[i] = pat_b[i];

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ena",    ena_a,    0);
        check("rst_addr",   addr_a,   0);
        check("rst_tvalid", tvalid_a, 0);
        check("rst_tdata",  tdata_a,  0);
        check("rst_free",   free_a,   0);
        check("rst_avail",  avail_a,  0);
        check("rst_ovf",    ovf_a,    0);

        // Four words, m_tready high
        @(negedge clk);
        ia = iss_addr_a.size(); ic = iss_cyc_a.size(); ba = beat_a.size();
        bc = beat_cyc_a.size(); fa = nfree_a;
        fill_a = 3'd4;
        @(negedge clk);
        fill_a = 3'd0;
        repeat (10) @(negedge clk);
        #1;
        check("t1_nissue", iss_addr_a.size() - ia, 4);
        check("t1_nbeat",  beat_a.size() - ba, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), qget(iss_addr_a, ia + i), i);
            check($sformatf("t1_icyc%0d", i), qget(iss_cyc_a, ic + i) - qget(iss_cyc_a, ic), i);
            check($sformatf("t1_data%0d", i), qget(beat_a, ba + i), i + 1);
            check($sformatf("t1_bcyc%0d", i), qget(beat_cyc_a, bc + i) - qget(beat_cyc_a, bc), i);
        end
        check("t1_latency", qget(beat_cyc_a, bc) - qget(iss_cyc_a, ic), 2);
        check("t1_nfree",   nfree_a - fa, 4);
        check("t1_avail",   avail_a, 0);
        check("t1_tvalid",  tvalid_a, 0);

        // Backpressure with avail=8
        @(negedge clk);
        ia = iss_addr_a.size(); ba = beat_a.size(); bc = beat_cyc_a.size(); fa = nfree_a;
        tready_a = 1'b0; fill_a = 3'd4;
        @(negedge clk);
        fill_a = 3'd4;
        @(negedge clk);
        fill_a = 3'd0;
        repeat (6) @(negedge clk);
        #1;
        check("t2_nissue_held", iss_addr_a.size() - ia, 2);
        check("t2_addr0",       qget(iss_addr_a, ia), 4);
        check("t2_addr1",       qget(iss_addr_a, ia + 1), 5);
        check("t2_nbeat_held",  beat_a.size() - ba, 0);
        check("t2_ena_held",    ena_a, 0);
        check("t2_tvalid_held", tvalid_a, 1);
        check("t2_tdata_held",  tdata_a, 4'hA);
        check("t2_avail_held",  avail_a, 6);
        check("t2_free_held",   nfree_a - fa, 2);
        @(negedge clk);
        tready_a = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("t2_nissue", iss_addr_a.size() - ia, 8);
        check("t2_nbeat",  beat_a.size() - ba, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_addr%0d", i), qget(iss_addr_a, ia + i), 4 + i);
            check($sformatf("t2_data%0d", i), qget(beat_a, ba + i), pat_a2[i]);
            check($sformatf("t2_bcyc%0d", i), qget(beat_cyc_a, bc + i) - qget(beat_cyc_a, bc), i);
        end
        check("t2_free",  nfree_a - fa, 8);
        check("t2_avail", avail_a, 0);

        // Simultaneous fill and issue
        @(negedge clk);
        fill_a = 3'd1;
        @(negedge clk);
        fill_a = 3'd2;
        #1;
        check("t4_avail_before", avail_a, 1);
        check("t4_ena",          ena_a, 1);
        @(negedge clk);
        fill_a = 3'd0;
        #1;
        check("t4_avail_after", avail_a, 2);
        repeat (6) @(negedge clk);

        // Reset with one read in flight and one beat buffered
        @(negedge clk);
        tready_a = 1'b0; fill_a = 3'd4;
        @(negedge clk);
        fill_a = 3'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_pre_tvalid", tvalid_a, 1);
        check("t6_pre_free",   free_a, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t6_tvalid", tvalid_a, 0);
        check("t6_avail",  avail_a, 0);
        check("t6_free",   free_a, 0);
        check("t6_addr",   addr_a, 0);
        check("t6_ena",    ena_a, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("t6_post_free",   free_a, 0);
        check("t6_post_tvalid", tvalid_a, 0);
        @(negedge clk);
        #1;
        check("t6_post2_tvalid", tvalid_a, 0);
        tready_a = 1'b1;

        // SIZEB=6 wrap: 14 words
        @(negedge clk);
        ib = iss_addr_b.size(); bb = beat_b.size(); fb = nfree_b;
        tready_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            fill_b = 3'(fill_tab[i]);
            @(negedge clk);
        end
        fill_b = 3'd0;
        repeat (20) @(negedge clk);
        #1;
        check("t3_nissue", iss_addr_b.size() - ib, 14);
        check("t3_nbeat",  beat_b.size() - bb, 14);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("t3_addr%0d", i), qget(iss_addr_b, ib + i), i % 6);
            check($sformatf("t3_data%0d", i), qget(beat_b, bb + i), pat_b[i % 6]);
        end
        check("t3_free",  nfree_b - fb, 14);
        check("t3_avail", avail_b, 0);
        check("t3_ovf",   ovf_b, 0);

        // Overflow on SIZEB=6
        @(negedge clk);
        rst = 1'b1; tready_b = 1'b0;
        @(negedge clk);
        rst = 1'b0; fill_b = 3'd4;
        @(negedge clk);
        fill_b = 3'd2;
        @(negedge clk);
        fill_b = 3'd1;
        @(negedge clk);
        fill_b = 3'd1;
        @(negedge clk);
        fill_b = 3'd1;
        #1;
        check("t5_avail_full", avail_b, 6);
        check("t5_ovf_before", ovf_b, 0);
        check("t5_ena_full",   ena_b, 0);
        @(negedge clk);
        fill_b = 3'd0;
        #1;
        check("t5_ovf_set",   ovf_b, 1);
        check("t5_avail_sat", avail_b, 6);
        @(negedge clk);
        #1;
        check("t5_ovf_sticky", ovf_b, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("t5_ovf_cleared",   ovf_b, 0);
        check("t5_avail_cleared", avail_b, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
